// File: rtl/serial_adder.sv
// Digit-serial WIDTH-bit adder: one DIGIT-wide slice reused over WIDTH/DIGIT cycles.
// Build option SERIAL_ADDER_SUB_EN adds a 'sub' port that turns the operation into A - B.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic [1:0]       fsm_state
);

  // Handshake: start is a request taken on any rising edge where busy=0
  // (IDLE or the DONE cycle); done is a one-cycle pulse with Sum/Carry valid,
  // and Sum/Carry then hold until the next done.

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] next_sum;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             accept;

  // Subtraction reuses the add slice: A + ~B + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~B : B;
  assign c_load = sub ? 1'b1 : Cin;
`else
  assign b_load = B;
  assign c_load = Cin;
`endif

  assign slice = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, c_reg};

  generate
    if (WIDTH == DIGIT) begin : g_single_digit
      assign next_sum = slice[DIGIT-1:0];
    end else begin : g_multi_digit
      assign next_sum = {slice[DIGIT-1:0], sum_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign accept = start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_sh  <= A;
            b_sh  <= b_load;
            c_reg <= c_load;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          c_reg  <= slice[DIGIT];
          sum_sh <= next_sum;
          cnt    <= cnt + CW'(1);
          // The final digit lands directly in the result registers.
          if (cnt == LAST) begin
            sum_q   <= next_sum;
            carry_q <= slice[DIGIT];
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign Sum       = sum_q;
  assign Carry     = carry_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four instances (8/1, 8/4, 4/1, 4/2) checked against
// an arithmetic reference model through an expected-result queue.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start_v = 4'b0;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic       cin = 1'b0;
  logic       sub_in = 1'b0;

  wire  [3:0] busy_v;
  wire  [3:0] done_v;
  wire  [7:0] s0, s1;
  wire  [3:0] s2, s3;
  wire        c0, c1, c2, c3;
  wire  [1:0] st0, st1, st2, st3;
  logic [8:0] res [4];

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_in), .B(b_in), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_in),
`endif
    .busy(busy_v[0]), .done(done_v[0]), .Sum(s0), .Carry(c0), .fsm_state(st0));

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_in), .B(b_in), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_in),
`endif
    .busy(busy_v[1]), .done(done_v[1]), .Sum(s1), .Carry(c1), .fsm_state(st1));

  serial_adder #(.WIDTH(4), .DIGIT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_in[3:0]), .B(b_in[3:0]), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_in),
`endif
    .busy(busy_v[2]), .done(done_v[2]), .Sum(s2), .Carry(c2), .fsm_state(st2));

  serial_adder #(.WIDTH(4), .DIGIT(2)) dut3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .A(a_in[3:0]), .B(b_in[3:0]), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_in),
`endif
    .busy(busy_v[3]), .done(done_v[3]), .Sum(s3), .Carry(c3), .fsm_state(st3));

  assign res[0] = {c0, s0};
  assign res[1] = {c1, s1};
  assign res[2] = {4'b0, c2, s2};
  assign res[3] = {4'b0, c3, s3};

  // Reference: {Carry, Sum} of A + B + Cin, or A - B + 2^w when subtracting.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic ci, input logic sb, input int w);
    int unsigned r;
    if (sb) r = int'(a) + (1 << w) - int'(b);
    else    r = int'(a) + int'(b) + int'(ci);
    return r[8:0];
  endfunction

  function automatic int cycles_of(input int sel);
    case (sel)
      0: return 8;
      1: return 2;
      2: return 4;
      default: return 2;
    endcase
  endfunction

  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb);
    int w, n, busy_cnt;
    bit got;
    logic [7:0] am, bm;
    logic [8:0] exp;
    w = (sel < 2) ? 8 : 4;
    n = cycles_of(sel);
    am = (w == 4) ? (a & 8'h0F) : a;
    bm = (w == 4) ? (b & 8'h0F) : b;
    exp_q.push_back(model(am, bm, ci, sb, w));
    @(negedge clk);
    a_in = am; b_in = bm; cin = ci; sub_in = sb; start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom_range(0, 1));
    busy_cnt = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done_v[sel]) got = 1;
      else begin
        if (busy_v[sel]) busy_cnt++;
        @(negedge clk);
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL op_timeout dut%0d a=%h b=%h: got no done, required done within 40 cycles", sel, am, bm);
    end
    checks++;
    if (busy_cnt !== n) begin
      failures++;
      $display("FAIL busy_cycles dut%0d: got %0d, required %0d", sel, busy_cnt, n);
    end
    checks++;
    if (res[sel] !== exp) begin
      failures++;
      $display("FAIL result dut%0d a=%h b=%h cin=%b sub=%b: got %h, required %h",
               sel, am, bm, ci, sb, res[sel], exp);
    end
    @(negedge clk);
    checks++;
    if (done_v[sel] !== 1'b0 || res[sel] !== exp) begin
      failures++;
      $display("FAIL done_pulse_hold dut%0d: got done=%b res=%h, required done=0 res=%h",
               sel, done_v[sel], res[sel], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      checks++;
      if (busy_v !== 4'b0 || done_v !== 4'b0 || res[0] !== 9'h0 || res[1] !== 9'h0 ||
          res[2] !== 9'h0 || res[3] !== 9'h0 || st0 !== 2'd0 || st2 !== 2'd0) begin
        failures++;
        $display("FAIL reset_state step%0d: got busy=%b done=%b r0=%h r1=%h r2=%h r3=%h, required all 0",
                 i, busy_v, done_v, res[0], res[1], res[2], res[3]);
      end
    end
  endtask

  task automatic test_vectors();
    run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(1, 8'h99, 8'h88, 1'b0, 1'b0);
    checks++;
    if (res[1] !== 9'h121) begin
      failures++;
      $display("FAIL digit4_vector: got %h, required 121", res[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_op(i % 4, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_ignore_start();
    logic [8:0] exp;
    bit got;
    exp = model(8'hA7, 8'h6B, 1'b1, 1'b0, 8);
    @(negedge clk);
    a_in = 8'hA7; b_in = 8'h6B; cin = 1'b1; start_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom_range(0, 1));
    end
    start_v[0] = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done_v[0]) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got || res[0] !== exp) begin
      failures++;
      $display("FAIL ignore_start: got done=%b res=%h, required done=1 res=%h", got, res[0], exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp1, exp2;
    logic [7:0] a2, b2;
    bit got;
    int gap;
    a2 = 8'($urandom); b2 = 8'($urandom);
    exp1 = model(8'hC3, 8'h5D, 1'b0, 1'b0, 8);
    exp2 = model(a2, b2, 1'b1, 1'b0, 8);
    @(negedge clk);
    a_in = 8'hC3; b_in = 8'h5D; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done_v[0]) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got || res[0] !== exp1) begin
      failures++;
      $display("FAIL b2b_first: got done=%b res=%h, required done=1 res=%h", got, res[0], exp1);
    end
    a_in = a2; b_in = b2; cin = 1'b1; start_v[0] = 1'b1;
    gap = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      gap++;
      if (gap == 3) begin
        checks++;
        if (res[0] !== exp1 || busy_v[0] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_hold_in_run: got busy=%b res=%h, required busy=1 res=%h",
                   busy_v[0], res[0], exp1);
        end
      end
      if (done_v[0]) got = 1;
    end
    checks++;
    if (!got || gap !== 9) begin
      failures++;
      $display("FAIL b2b_gap: got done=%b gap=%0d, required done=1 gap=9", got, gap);
    end
    checks++;
    if (res[0] !== exp2) begin
      failures++;
      $display("FAIL b2b_second: got %h, required %h", res[0], exp2);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    a_in = 8'h77; b_in = 8'h99; cin = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || res[0] !== 9'h0 || st0 !== 2'd0) begin
      failures++;
      $display("FAIL abort_reset: got busy=%b done=%b res=%h state=%0d, required all 0",
               busy_v[0], done_v[0], res[0], st0);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    checks++;
    if (seen !== 0 || res[0] !== 9'h0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d done pulses res=%h, required 0 pulses res=000", seen, res[0]);
    end
    run_op(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_exhaustive();
    logic [8:0] v;
    $monitor("monitor t=%0t w4d1 sum=%h carry=%b", $time, s2, c2);
    for (int sel = 2; sel < 4; sel++) begin
      for (int i = 0; i < 512; i++) begin
        v = 9'(i);
        run_op(sel, {4'h0, v[3:0]}, {4'h0, v[7:4]}, v[8], 1'b0);
      end
      if (sel == 2) $monitoroff;
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    run_op(0, 8'h10, 8'h01, 1'b0, 1'b1);
    run_op(0, 8'h01, 8'h02, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++)
      run_op(i % 4, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
